// File: rtl/alu_result_buf.sv
// DEPTH-entry ALU result queue with valid/ready on both sides; dataout is the registered head.
// Optional macro ALURES_FLAGS_EN adds per-entry {neg,zero} flags and the flags output port.
module alu_result_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           datain,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           dataout,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef ALURES_FLAGS_EN
    ,
    output logic [1:0]                 flags
`endif
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
`ifdef ALURES_FLAGS_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH;
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_in_ready;
    logic          r_out_valid;
    logic [EW-1:0] r_head;

    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_remain;
    logic [CW-1:0] w_count_nxt;
    logic [PW-1:0] w_rd_nxt;
    logic [EW-1:0] w_in_entry;
    logic [EW-1:0] w_head_nxt;

`ifdef ALURES_FLAGS_EN
    assign w_in_entry = {datain[WIDTH-1], (datain == '0), datain};
    assign flags      = r_head[WIDTH+1:WIDTH];
`else
    assign w_in_entry = datain;
`endif

    assign w_push    = in_valid & r_in_ready;
    assign w_pop     = r_out_valid & out_ready;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign dataout   = r_head[WIDTH-1:0];

    // The head register is loaded with the entry that will be oldest after this
    // edge; when the queue drains to zero in the same cycle, that is the incoming word.
    always_comb begin
        w_remain    = r_count - CW'(w_pop);
        w_count_nxt = w_remain + CW'(w_push);
        w_rd_nxt    = r_rd_ptr + PW'(w_pop);
        w_head_nxt  = r_head;
        if (w_count_nxt != '0) begin
            if (w_remain == '0) begin
                w_head_nxt = w_in_entry;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst && !flush) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + PW'(w_push);
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < CW'(DEPTH));
            r_out_valid <= (w_count_nxt != '0);
            r_head      <= w_head_nxt;
        end
    end

endmodule
